lut_ram_burst_ctrl: RTL and testbench

- Burst sequencer placed directly upstream of the 32x2048 LUT RAM.
- Accepts one burst command (start address, length, direction), then drives the RAM's single port.
- Write bursts take a valid/ready write-data stream; read bursts return a valid/ready read-data stream.
- Absorbs the RAM's 1-cycle synchronous read latency with a 2-entry output buffer. Sustains 1 word/cycle when the downstream side is never stalled.

---
 rtl/lut_ram_pkg.sv | 19 +
 rtl/burst_skid_fifo.sv | 51 +++++
 rtl/lut_ram_burst_ctrl.sv | 166 ++++++++++++++++
 tb/tb_lut_ram_burst_ctrl.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_ram_pkg.sv
// Shared definitions for the LUT RAM burst controller: default geometry,
// burst FSM states and RAM operation encoding.
package lut_ram_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 2048;

    localparam logic RAM_OP_READ  = 1'b1;
    localparam logic RAM_OP_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } burst_state_t;

endpackage

// File: rtl/burst_skid_fifo.sv
// Two-entry valid/ready FIFO that catches RAM read data one cycle after issue.
// Occupancy is exported so the issuer can avoid overflowing it.
module burst_skid_fifo
    import lut_ram_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             pop;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    // Simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lut_ram_burst_ctrl.sv
// Burst sequencer in front of the single-port LUT RAM (write stream in, read stream out).
// Optional BURST_CHECKSUM_EN adds an XOR checksum of the last completed burst.
module lut_ram_burst_ctrl
    import lut_ram_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_read,
    input  logic [$clog2(DEPTH)-1:0] cmd_addr,
    input  logic [LW-1:0]            cmd_len,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     done,
    output logic                     ram_write_read_en,
    output logic [$clog2(DEPTH)-1:0] ram_address,
    output logic [WIDTH-1:0]         ram_din,
    input  logic [WIDTH-1:0]         ram_dout
`ifdef BURST_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0]         checksum
`endif
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [LW-1:0] MAX_LEN   = LW'(DEPTH);

    burst_state_t    state;
    burst_state_t    next_state;
    logic [AW-1:0]   ptr;
    logic [LW-1:0]   remaining;
    logic [LW-1:0]   len_clamped;
    logic            in_flight;
    logic            cmd_fire;
    logic            wr_fire;
    logic            issue_rd;
    logic            rd_pop;
    logic [1:0]      fifo_count;
    logic [2:0]      occ_after;

    assign len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign rd_pop      = rd_valid && rd_ready;

    // Slots already committed once this cycle's pop is taken into account.
    assign occ_after = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, rd_pop};

    assign ram_write_read_en = wr_fire ? RAM_OP_WRITE : RAM_OP_READ;
    assign ram_address       = ptr;
    assign ram_din           = wr_fire ? wr_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        wr_ready   = 1'b0;
        done       = 1'b0;
        wr_fire    = 1'b0;
        issue_rd   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (len_clamped == '0) begin
                        next_state = DONE;
                    end else if (cmd_read) begin
                        next_state = READ;
                    end else begin
                        next_state = WRITE;
                    end
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                wr_fire  = wr_valid;
                if (wr_valid && (remaining == LW'(1))) begin
                    next_state = DONE;
                end
            end
            READ: begin
                if (occ_after < 3'd2) begin
                    issue_rd = 1'b1;
                    if (remaining == LW'(1)) begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!in_flight && (fifo_count == 2'd0)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            remaining <= '0;
            in_flight <= 1'b0;
        end else begin
            in_flight <= issue_rd;
            if (cmd_fire) begin
                ptr       <= cmd_addr;
                remaining <= len_clamped;
            end else if (wr_fire || issue_rd) begin
                ptr       <= (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

    burst_skid_fifo #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_flight),
        .push_data (ram_dout),
        .out_valid (rd_valid),
        .out_ready (rd_ready),
        .out_data  (rd_data),
        .count     (fifo_count)
    );

`ifdef BURST_CHECKSUM_EN
    logic [WIDTH-1:0] acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (cmd_fire) begin
            acc <= '0;
        end else if (wr_fire) begin
            acc <= acc ^ wr_data;
        end else if (rd_pop) begin
            acc <= acc ^ rd_data;
        end
    end

    assign checksum = acc;
`endif

endmodule

// File: tb/tb_lut_ram_burst_ctrl.sv
// Self-checking bench for lut_ram_burst_ctrl with a behavioural RAM and write/read scoreboards.
// Covers BURST_CHECKSUM_EN when the macro is defined.
module tb_lut_ram_burst_ctrl;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2048;
    localparam int AW    = 11;
    localparam int LW    = 12;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } wr_exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_read;
    logic [AW-1:0]    cmd_addr;
    logic [LW-1:0]    cmd_len;
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic             done;
    logic             ram_write_read_en;
    logic [AW-1:0]    ram_address;
    logic [WIDTH-1:0] ram_din;
    logic [WIDTH-1:0] ram_dout;
`ifdef BURST_CHECKSUM_EN
    logic [WIDTH-1:0] checksum;
`endif

    int checks = 0;
    int errors = 0;

    wr_exp_t          exp_wr_q [$];
    logic [WIDTH-1:0] exp_rd_q [$];
    logic [WIDTH-1:0] wr_src_q [$];
    logic [WIDTH-1:0] ref_mem  [DEPTH];
    logic [WIDTH-1:0] ram_mem  [DEPTH];

    always #5 clk = ~clk;

    lut_ram_burst_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_read          (cmd_read),
        .cmd_addr          (cmd_addr),
        .cmd_len           (cmd_len),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_data           (wr_data),
        .rd_valid          (rd_valid),
        .rd_ready          (rd_ready),
        .rd_data           (rd_data),
        .done              (done),
        .ram_write_read_en (ram_write_read_en),
        .ram_address       (ram_address),
        .ram_din           (ram_din),
        .ram_dout          (ram_dout)
`ifdef BURST_CHECKSUM_EN
        ,
        .checksum          (checksum)
`endif
    );

    // Behavioural single-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_write_read_en == 1'b0) begin
            ram_mem[ram_address] <= ram_din;
        end
        ram_dout <= ram_mem[ram_address];
    end

    task automatic send_cmd(input bit rd, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        bit ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_read  = rd;
        cmd_addr  = addr;
        cmd_len   = len;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL cmd_accept: cmd_ready never seen, got 0 expected 1");
        end
    endtask

    task automatic write_burst(input logic [AW-1:0] addr, input int len, input bit gaps);
        wr_exp_t          e;
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] xr;
        int               idx;
        int               done_cnt;
        int               done_at;
        int               last_hs;
        xr = '0;
        for (int i = 0; i < len; i++) begin
            a      = addr + AW'(i);
            e.addr = a;
            e.data = wr_src_q[i];
            exp_wr_q.push_back(e);
            ref_mem[a] = e.data;
            xr         = xr ^ e.data;
        end
        send_cmd(1'b0, addr, LW'(len));
        idx      = 0;
        done_cnt = 0;
        done_at  = -1;
        last_hs  = -1;
        for (int cyc = 0; cyc < 3 * len + 10; cyc++) begin
            wr_valid = (idx < len) && !(gaps && (cyc % 3 == 1));
            wr_data  = (idx < len) ? wr_src_q[idx] : 32'hDEAD_BEEF;
            @(negedge clk);
            checks++;
            if (wr_valid && wr_ready) begin
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL wr_extra: got write at %h, expected none", ram_address);
                end else begin
                    e = exp_wr_q.pop_front();
                    if (ram_write_read_en !== 1'b0 || ram_address !== e.addr || ram_din !== e.data) begin
                        errors++;
                        $display("[TB] FAIL ram_write: got en=%b addr=%h din=%h expected en=0 addr=%h din=%h",
                                 ram_write_read_en, ram_address, ram_din, e.addr, e.data);
                    end
                end
                idx++;
                last_hs = cyc;
            end else if (ram_write_read_en !== 1'b1) begin
                errors++;
                $display("[TB] FAIL spurious_write: got en=%b expected 1", ram_write_read_en);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_at = cyc;
`ifdef BURST_CHECKSUM_EN
                checks++;
                if (checksum !== xr) begin
                    errors++;
                    $display("[TB] FAIL wr_checksum: got %h expected %h", checksum, xr);
                end
`endif
            end
            @(posedge clk); #1;
            if (done_at >= 0 && cyc > done_at) break;
        end
        wr_valid = 1'b0;
        checks++;
        if (idx != len) begin
            errors++;
            $display("[TB] FAIL wr_count: got %0d expected %0d", idx, len);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL wr_done_count: got %0d expected 1", done_cnt);
        end
        checks++;
        if (done_at != last_hs + 1) begin
            errors++;
            $display("[TB] FAIL wr_done_timing: got cycle %0d expected %0d", done_at, last_hs + 1);
        end
        checks++;
        if (exp_wr_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL wr_pending: got %0d left expected 0", exp_wr_q.size());
        end
        exp_wr_q.delete();
        wr_src_q.delete();
    endtask

    task automatic read_burst(input logic [AW-1:0] addr, input int len, input bit toggle);
        logic [AW-1:0]    a;
        logic [AW-1:0]    diff;
        logic [WIDTH-1:0] xr;
        logic [WIDTH-1:0] e;
        logic [WIDTH-1:0] prev_data;
        bit               prev_stall;
        int               popped;
        int               first_valid;
        int               last_pop;
        int               done_cnt;
        int               done_at;
        int               outstanding;
        xr = '0;
        for (int i = 0; i < len; i++) begin
            a = addr + AW'(i);
            exp_rd_q.push_back(ref_mem[a]);
            xr = xr ^ ref_mem[a];
        end
        send_cmd(1'b1, addr, LW'(len));
        popped      = 0;
        first_valid = -1;
        last_pop    = -1;
        done_cnt    = 0;
        done_at     = -1;
        prev_stall  = 1'b0;
        prev_data   = '0;
        for (int cyc = 0; cyc < 4 * len + 12; cyc++) begin
            rd_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            @(negedge clk);
            checks++;
            if (ram_write_read_en !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rd_spurious_write: got en=%b expected 1", ram_write_read_en);
            end
            diff        = ram_address - addr;
            outstanding = int'(diff) - popped;
            checks++;
            if (outstanding < 0 || outstanding > 2) begin
                errors++;
                $display("[TB] FAIL rd_outstanding: got %0d expected 0..2", outstanding);
            end
            if (prev_stall) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== prev_data) begin
                    errors++;
                    $display("[TB] FAIL rd_hold: got valid=%b data=%h expected valid=1 data=%h",
                             rd_valid, rd_data, prev_data);
                end
            end
            if (rd_valid === 1'b1 && first_valid < 0) first_valid = cyc;
            if (rd_valid === 1'b1 && rd_ready) begin
                checks++;
                if (exp_rd_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rd_extra: got %h expected no word", rd_data);
                end else begin
                    e = exp_rd_q.pop_front();
                    if (rd_data !== e) begin
                        errors++;
                        $display("[TB] FAIL rd_data: got %h expected %h", rd_data, e);
                    end
                end
                popped++;
                last_pop = cyc;
            end
            prev_stall = (rd_valid === 1'b1) && !rd_ready;
            prev_data  = rd_data;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = cyc;
`ifdef BURST_CHECKSUM_EN
                checks++;
                if (checksum !== xr) begin
                    errors++;
                    $display("[TB] FAIL rd_checksum: got %h expected %h", checksum, xr);
                end
`endif
            end
            @(posedge clk); #1;
            if (done_at >= 0 && cyc > done_at) break;
        end
        rd_ready = 1'b0;
        checks++;
        if (popped != len) begin
            errors++;
            $display("[TB] FAIL rd_count: got %0d expected %0d", popped, len);
        end
        checks++;
        if (done_cnt != 1 || done_at <= last_pop) begin
            errors++;
            $display("[TB] FAIL rd_done: got count=%0d at %0d expected 1 after %0d", done_cnt, done_at, last_pop);
        end
        if (!toggle) begin
            checks++;
            if (first_valid != 2) begin
                errors++;
                $display("[TB] FAIL rd_latency: got %0d expected 2", first_valid);
            end
            checks++;
            if (last_pop != first_valid + len - 1) begin
                errors++;
                $display("[TB] FAIL rd_throughput: got last pop %0d expected %0d", last_pop, first_valid + len - 1);
            end
        end
        exp_rd_q.delete();
        xr = '0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_read  = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || wr_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got cmd_ready=%b wr_ready=%b done=%b expected 1 0 0",
                     cmd_ready, wr_ready, done);
        end
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_rd: got valid=%b data=%h expected 0 0", rd_valid, rd_data);
        end
        checks++;
        if (ram_write_read_en !== 1'b1 || ram_address !== '0 || ram_din !== '0) begin
            errors++;
            $display("[TB] FAIL reset_ram: got en=%b addr=%h din=%h expected 1 0 0",
                     ram_write_read_en, ram_address, ram_din);
        end
        @(posedge clk); #1;
        reset    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 32'h5555_AAAA;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b0 || ram_write_read_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL idle_wr_ignored: got wr_ready=%b en=%b expected 0 1", wr_ready, ram_write_read_en);
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic test_write_wrap();
        for (int i = 0; i < 4; i++) wr_src_q.push_back(32'hA0 + i);
        write_burst(11'h7FE, 4, 1'b0);
    endtask

    task automatic test_read_stream();
        read_burst(11'h7FE, 4, 1'b0);
    endtask

    task automatic test_read_backpressure();
        for (int i = 0; i < 6; i++) wr_src_q.push_back($urandom);
        write_burst(11'h100, 6, 1'b1);
        read_burst(11'h100, 6, 1'b1);
    endtask

    task automatic test_zero_len();
        for (int r = 0; r < 2; r++) begin
            send_cmd(r[0], 11'h123, '0);
            @(negedge clk);
            checks++;
            if (done !== 1'b1 || cmd_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL zero_len_done: got done=%b cmd_ready=%b expected 1 0", done, cmd_ready);
            end
            checks++;
            if (ram_write_read_en !== 1'b1 || rd_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL zero_len_access: got en=%b rd_valid=%b expected 1 0", ram_write_read_en, rd_valid);
            end
`ifdef BURST_CHECKSUM_EN
            checks++;
            if (checksum !== '0) begin
                errors++;
                $display("[TB] FAIL zero_len_checksum: got %h expected 0", checksum);
            end
`endif
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL zero_len_idle: got done=%b cmd_ready=%b expected 0 1", done, cmd_ready);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [AW-1:0] diff;
        send_cmd(1'b1, 11'h7FE, LW'(4));
        rd_ready = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (cyc == 4) begin
                diff = ram_address - 11'h7FE;
                checks++;
                if (rd_valid !== 1'b1 || diff !== 11'd2) begin
                    errors++;
                    $display("[TB] FAIL fifo_full: got valid=%b issued=%0d expected 1 2", rd_valid, diff);
                end
            end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort: got rd_valid=%b cmd_ready=%b done=%b expected 0 1 0", rd_valid, cmd_ready, done);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || rd_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL abort_quiet: got done=%b rd_valid=%b expected 0 0", done, rd_valid);
            end
        end
        @(posedge clk); #1;
        read_burst(11'h7FE, 4, 1'b0);
    endtask

`ifdef BURST_CHECKSUM_EN
    task automatic test_checksum();
        wr_src_q.push_back(32'h1);
        wr_src_q.push_back(32'h2);
        wr_src_q.push_back(32'h4);
        write_burst(11'h040, 3, 1'b0);
        @(negedge clk);
        checks++;
        if (checksum !== 32'h7) begin
            errors++;
            $display("[TB] FAIL checksum_hold: got %h expected 00000007", checksum);
        end
        @(posedge clk); #1;
        read_burst(11'h040, 3, 1'b0);
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_write_wrap();
        test_read_stream();
        test_read_backpressure();
        test_zero_len();
        test_reset_mid_burst();
`ifdef BURST_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
